// File: rtl/hazard_ctl.sv
// Pipeline hazard/sequencing controller for the 5-stage MIPS pipeline:
// load-use bubbles, taken-branch squash, memory-busy freeze with deferred flush.
module hazard_ctl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {RUN, FREEZE} state_e;

  state_e           state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic flush_req;

  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign flush_req = mem_branch_taken || pend_flush_q;

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    timer_d      = timer_q;
    timeout_d    = timeout_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pipe_freeze  = 1'b0;

    unique case (state_q)
      RUN:    if (mem_busy)  state_d = FREEZE;
      FREEZE: if (!mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (mem_busy) begin
      if (timer_q != TMR_MAX) timer_d = timer_q + TW'(1);
      if (timer_q >= TMR_LAST) timeout_d = 1'b1;
    end else begin
      timer_d = '0;
    end

    // Outputs are held low while in reset; registers are cleared asynchronously.
    if (rst) begin
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        if (mem_branch_taken) pend_flush_d = 1'b1;
      end else if (flush_req) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        pend_flush_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (lu) begin
        idex_bubble = 1'b1;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign timeout_err = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: per-cycle expected controls are queued when
// driven and compared mid-cycle; counters/timeout come from a small model.
module tb_hazard_ctl;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [CNT_W-1:0] SAT = '1;

  // {pipe_freeze, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush}
  localparam logic [6:0] C_ZERO  = 7'b0000000;
  localparam logic [6:0] C_RUN   = 7'b0110000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_FLUSH = 7'b0110111;
  localparam logic [6:0] C_FRZ   = 7'b1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, mem_branch_taken = 1'b0, mem_busy = 1'b0;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic pipe_freeze, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
  logic m_to = 1'b0;
  int m_run = 0;

  hazard_ctl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_freeze(pipe_freeze), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_now();
    return {pipe_freeze, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [6:0] e;
    e = exp_q.pop_front();
    chk({tag, ".ctl"}, 32'(ctl_now()), 32'(e));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    chk({tag, ".timeout"}, 32'(timeout_err), 32'(m_to));
  endtask

  // One pipeline cycle: drive, queue expectation, compare mid-cycle, advance model.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses_rt, input logic memrd, input logic [4:0] exrt,
                      input logic br, input logic busy, input logic [6:0] e);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
    ex_memread = memrd; ex_rt = exrt; mem_branch_taken = br; mem_busy = busy;
    exp_q.push_back(e);
    @(negedge clk);
    chk_state(tag);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e[3] && m_stall != SAT) m_stall = m_stall + 1'b1;
      if (e[0] && m_flush != SAT) m_flush = m_flush + 1'b1;
      m_run = busy ? m_run + 1 : 0;
      if (m_run >= int'(TIMEOUT)) m_to = 1'b1;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN);
  endtask

  initial begin
    // Reset held: combinational outputs all low even with benign inputs.
    step("reset", 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_ZERO);
    rst_n = 1'b1;

    idle("idle");
    step("lu_rs", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, C_STALL);
    idle("lu_rs_after");
    step("lu_r0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN);
    step("rt_nouse", 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, C_RUN);
    step("rt_use", 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, C_STALL);
    idle("rt_after");

    step("branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH);
    idle("branch_after");

    step("defer_c1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_FRZ);
    for (int i = 0; i < 3; i++)
      step("defer_frz", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, C_FRZ);
    step("defer_c5", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_FLUSH);
    idle("defer_after");

    step("pri_lu_br", 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, C_FLUSH);
    step("pri_lu_busy", 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, C_FRZ);
    step("pri_lu_release", 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, C_STALL);
    idle("pri_after");

    step("hold_br_frz1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_FRZ);
    step("hold_br_frz2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_FRZ);
    step("hold_br_rel", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH);
    idle("hold_br_after");

    for (int i = 0; i < 10; i++)
      step("timeout_busy", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, C_FRZ);
    idle("timeout_sticky1");
    idle("timeout_sticky2");

    for (int i = 0; i < 6; i++) begin
      step("sat_stall", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, C_STALL);
      idle("sat_stall_gap");
    end
    for (int i = 0; i < 4; i++) begin
      step("sat_flush", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH);
      idle("sat_flush_gap");
    end
    chk("sat_stall_final", 32'(stall_cnt), 32'(SAT));
    chk("sat_flush_final", 32'(flush_cnt), 32'(SAT));

    // Freeze with a flush pending, then async reset mid-cycle.
    step("rst_frz", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, C_FRZ);
    mem_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    m_stall = '0; m_flush = '0; m_to = 1'b0; m_run = 0;
    #1;
    exp_q.push_back(C_ZERO);
    chk_state("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle("rst_restart");
    idle("rst_restart2");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. Sits beside the IF/ID, ID/EX and EX/MEM latches and drives their hold, bubble and flush controls:
- detects load-use hazards and inserts one bubble into ID/EX;
- squashes wrong-path instructions when a branch resolves taken in MEM;
- freezes the whole pipeline while data memory is busy, deferring any flush until the freeze ends;
- keeps saturating stall and flush counters, plus a sticky freeze-timeout flag.

## Interface
- CNT_W, 16, width of the stall and flush counters
- TIMEOUT, 255, consecutive freeze cycles that set timeout_err
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field (instr[25:21]) of the instruction in ID
- id_rt  in  5  rt field (instr[20:16]) of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt (R-type, beq, sw)
- ex_memread  in  1  MemRead bit of ID/EX m_ctlout (load in EX)
- ex_rt  in  5  ID/EX instrout_2016 (load destination)
- mem_branch_taken  in  1  branch in MEM resolved taken
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- idex_bubble  out  1  force ctlwb/ctlm/ctlex inputs of ID/EX to zero
- ifid_flush, idex_flush, exmem_flush  out  1 each  clear the latch on the next edge
- pipe_freeze  out  1  all pipeline latches hold
- timeout_err  out  1  sticky freeze-timeout flag
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  flush events issued, saturating

## Operation
**Load-use hazard.**
- lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).

**Flush request.**
- flush_req = mem_branch_taken || pend_flush.

**State machine.** Two states, RUN and FREEZE, plus pend_flush and freeze_timer registers.
- RUN → FREEZE when mem_busy=1.
- FREEZE → RUN when mem_busy=0.

**Output priority.** Outputs are combinational from state, registers and inputs. The first matching case applies.
1. mem_busy=1 (either state):
   - pipe_freeze=1, pc_write=0, ifid_write=0.
   - idex_bubble=0, all flushes 0.
   - If mem_branch_taken=1, set pend_flush.
2. flush_req=1 and mem_busy=0:
   - ifid_flush=idex_flush=exmem_flush=1; pc_write=1, so the PC loads the branch target; ifid_write=1.
   - idex_bubble=0.
   - Clear pend_flush; flush_cnt += 1.
   - lu is ignored this cycle, because the instruction in ID is squashed.
3. lu=1:
   - pc_write=0, ifid_write=0, idex_bubble=1.
   - stall_cnt += 1.
   - The hazard clears by itself next cycle, when the load has moved to MEM, so exactly one bubble is inserted per load.
4. Otherwise: pc_write=1, ifid_write=1, all other controls 0.

**Freeze timer.**
- freeze_timer increments each cycle mem_busy=1 and clears when mem_busy=0.
- When it reaches TIMEOUT, timeout_err sets and holds until reset.
- Freeze continues to follow mem_busy after timeout_err sets; there is no forced release.

**Counters.**
- Both counters saturate at all-ones (2^CNT_W − 1) and never wrap.

## Timing
- **Reset (rst=0, asynchronous):**
  - State=RUN; pend_flush=0, freeze_timer=0, timeout_err=0, stall_cnt=0, flush_cnt=0.
  - While rst=0, all combinational outputs are 0, including pc_write and ifid_write.
  - Reset mid-freeze or with a flush pending drops both; after release the block restarts in RUN.
- **Latency:**
  - Control outputs: zero cycles, same cycle as their inputs.
  - Counters, pend_flush and timeout_err: update on the rising edge that ends the triggering cycle.
- **Flush:**
  - Exactly one cycle per taken branch.
  - A branch that is taken during a freeze flushes in the first cycle with mem_busy=0, even if mem_branch_taken has dropped by then.
  - mem_branch_taken held high across the freeze still yields one flush only.
- **Simultaneous events:**
  - mem_busy and lu: freeze only; lu is re-evaluated after release.
  - flush_req and lu: flush only; stall_cnt does not increment.
- **Timeout:** with TIMEOUT=255, timeout_err is visible after the 255th consecutive busy edge.

## Test plan
- **Load-use:** ex_memread=1, ex_rt=5, id_rs=5, mem_busy=0 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for that cycle; stall_cnt=1. With ex_rt=0 -> no stall.
- **rt hazard gating:** ex_rt=7, id_rt=7, id_rs=3. With id_uses_rt=0 -> no stall. With id_uses_rt=1 -> one bubble.
- **Branch flush:** mem_branch_taken=1 for one cycle -> all three flushes=1 and pc_write=1 for exactly that cycle; flush_cnt=1.
- **Deferred flush:** mem_busy=1 for 4 cycles with mem_branch_taken=1 in the first cycle only -> pipe_freeze=1 and no flush for those 4 cycles; flush asserted in cycle 5 only; flush_cnt=1.
- **Priority:** lu=1 together with mem_branch_taken=1 -> flush, idex_bubble=0, stall_cnt unchanged. Then lu=1 together with mem_busy=1 -> freeze only.
- **Timeout and reset:** TIMEOUT=8, mem_busy=1 for 10 cycles -> timeout_err=1 from cycle 8 and stays set after mem_busy drops. Counters preset near saturation -> hold at all-ones. Assert rst=0 mid-freeze -> all outputs and counters read 0 immediately.
